// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall/flush sequencer for the 5-stage 16-bit core
//
// Purpose: arbitrates hazard stalls, branch redirects, instruction/data memory
// waits and WB-stage halt into per-stage register enables, IF/ID flush, ID/EX
// bubble and fetch cancel. Tracks halt/error state and saturating perf counters.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   hazard_stall      ID-stage RAW stall request
//   branch_taken      redirect resolved in ID this cycle
//   imem_stall        fetched word not valid this cycle
//   dmem_stall        data memory access started / continuing
//   dmem_done         data memory access completes this cycle
//   halt_wb           HALT instruction in WB
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en   stage register enables
//   ifid_flush        load NOP into IF/ID (always paired with ifid_en=1)
//   idex_bubble       load NOP into ID/EX
//   imem_cancel       abort outstanding fetch
//   halted, err       sticky halt / data memory timeout status
//   stall_cycles      cycles with pc_en=0 while running or waiting on dmem
//   flush_count       cycles with ifid_flush=1

module pipe_stall_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int SCNT_W      = 16,
   parameter int FCNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hazard_stall,
   input  logic              branch_taken,
   input  logic              imem_stall,
   input  logic              dmem_stall,
   input  logic              dmem_done,
   input  logic              halt_wb,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_en,
   output logic              idex_bubble,
   output logic              exmem_en,
   output logic              memwb_en,
   output logic              imem_cancel,
   output logic              halted,
   output logic              err,
   output logic [SCNT_W-1:0] stall_cycles,
   output logic [FCNT_W-1:0] flush_count
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DWAIT = 2'd1,
      S_HALT  = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t        state;
   logic [TW-1:0] tcnt;

   assign halted = (state == S_HALT);
   assign err    = (state == S_ERR);

   // Combinational enables. Everything defaults to frozen, so reset, HALT,
   // ERR and the dmem freeze need no explicit branch.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      imem_cancel = 1'b0;
      if (rst_n) begin
         case (state)
            S_RUN: begin
               if (halt_wb) begin
                  // freeze everything; HALT next
               end else if (dmem_stall && !dmem_done) begin
                  // multi-cycle data access: whole pipe frozen
               end else if (hazard_stall) begin
                  // hold PC and IF/ID, inject a bubble; any concurrent
                  // branch is re-evaluated once the dependence clears
                  idex_bubble = 1'b1;
                  idex_en     = 1'b1;
                  exmem_en    = 1'b1;
                  memwb_en    = 1'b1;
               end else if (branch_taken) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_en     = 1'b1;
                  exmem_en    = 1'b1;
                  memwb_en    = 1'b1;
                  imem_cancel = imem_stall;
               end else if (imem_stall) begin
                  // no valid fetch word: hold PC, push a NOP into IF/ID
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_en     = 1'b1;
                  exmem_en    = 1'b1;
                  memwb_en    = 1'b1;
               end else begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  idex_en     = 1'b1;
                  exmem_en    = 1'b1;
                  memwb_en    = 1'b1;
               end
            end
            S_DWAIT: begin
               // On completion the pipe advances unconditionally; the frozen
               // IF/ID re-presents any hazard/branch in the following cycle.
               if (dmem_done) begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
                  memwb_en = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_RUN;
         tcnt         <= '0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (halt_wb) begin
                  state <= S_HALT;
               end else if (dmem_stall && !dmem_done) begin
                  // the entry cycle is the first stalled cycle
                  tcnt  <= TW'(1);
                  state <= S_DWAIT;
               end
            end
            S_DWAIT: begin
               // halt_wb is not looked at here: WB is frozen
               if (dmem_done) begin
                  tcnt  <= '0;
                  state <= S_RUN;
               end else if (tcnt == TMAX) begin
                  state <= S_ERR;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: begin
               // HALT and ERR are absorbing until reset
            end
         endcase

         if ((state == S_RUN || state == S_DWAIT) && !pc_en && (stall_cycles != '1))
            stall_cycles <= stall_cycles + SCNT_W'(1);
         if (ifid_flush && (flush_count != '1))
            flush_count <= flush_count + FCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl

module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hazard_stall, branch_taken, imem_stall, dmem_stall, dmem_done, halt_wb;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, imem_cancel;
   logic        halted, err;
   logic [15:0] stall_cycles;
   logic [7:0]  flush_count;

   pipe_stall_ctrl #(.MEM_TIMEOUT(64), .SCNT_W(16), .FCNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .hazard_stall(hazard_stall), .branch_taken(branch_taken), .imem_stall(imem_stall),
      .dmem_stall(dmem_stall), .dmem_done(dmem_done), .halt_wb(halt_wb),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .imem_cancel(imem_cancel), .halted(halted), .err(err),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   // input bits: {hazard, branch, imem, dmem_stall, dmem_done, halt}
   localparam logic [5:0] I_HZ = 6'b100000;
   localparam logic [5:0] I_BR = 6'b010000;
   localparam logic [5:0] I_IM = 6'b001000;
   localparam logic [5:0] I_DS = 6'b000100;
   localparam logic [5:0] I_DD = 6'b000010;
   localparam logic [5:0] I_HL = 6'b000001;

   // output bits: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, imem_cancel}
   localparam logic [7:0] O_RUN  = 8'b11010110;
   localparam logic [7:0] O_HZ   = 8'b00011110;
   localparam logic [7:0] O_BR   = 8'b11110110;
   localparam logic [7:0] O_BRC  = 8'b11110111;
   localparam logic [7:0] O_IM   = 8'b01110110;
   localparam logic [7:0] O_FRZ  = 8'b00000000;

   typedef struct packed {
      logic [7:0] o;
      logic       h;
      logic       e;
   } exp_t;

   typedef struct {
      logic [5:0] in;
      logic [7:0] o;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        tbl[10];
   int          total = 0;
   int          bad = 0;
   logic [15:0] stall_m;
   logic [7:0]  flush_m;

   function automatic logic [7:0] outs();
      return {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, imem_cancel};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [5:0] in);
      {hazard_stall, branch_taken, imem_stall, dmem_stall, dmem_done, halt_wb} = in;
   endtask

   // Called just after a posedge: drive, push expectation, sample mid-cycle,
   // pop and compare, then advance to just after the next posedge.
   task automatic step(input string name, input logic [5:0] in, input logic [7:0] o,
                       input logic h, input logic e);
      exp_t x;
      drive(in);
      sb_q.push_back('{o: o, h: h, e: e});
      #2;
      if (sb_q.size() == 0) begin
         chk({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         x = sb_q.pop_front();
         chk({name, "_outs"}, 32'(outs()), 32'(x.o));
         chk({name, "_halted"}, 32'(halted), 32'(x.h));
         chk({name, "_err"}, 32'(err), 32'(x.e));
         if (!x.h && !x.e && !x.o[7] && stall_m != 16'hFFFF) stall_m++;
         if (x.o[5] && flush_m != 8'hFF) flush_m++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(6'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stall_m = '0;
      flush_m = '0;
   endtask

   task automatic chk_cnt(input string name);
      chk({name, "_stall_cycles"}, 32'(stall_cycles), 32'(stall_m));
      chk({name, "_flush_count"}, 32'(flush_count), 32'(flush_m));
   endtask

   initial begin
      tbl[0] = '{in: 6'b0,                 o: O_RUN};
      tbl[1] = '{in: I_HZ,                 o: O_HZ};
      tbl[2] = '{in: I_HZ | I_BR,          o: O_HZ};
      tbl[3] = '{in: I_BR,                 o: O_BR};
      tbl[4] = '{in: I_BR | I_IM,          o: O_BRC};
      tbl[5] = '{in: I_IM,                 o: O_IM};
      tbl[6] = '{in: I_HZ | I_IM,          o: O_HZ};
      tbl[7] = '{in: I_DS | I_DD,          o: O_RUN};
      tbl[8] = '{in: I_DS | I_DD | I_HZ,   o: O_HZ};
      tbl[9] = '{in: I_DD | I_IM,          o: O_IM};

      // reset held with all inputs high
      rst_n = 1'b0;
      drive(6'b111111);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rst_outs", 32'(outs()), 32'(O_FRZ));
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_flush", 32'(flush_count), 32'd0);
      drive(6'b0);
      rst_n = 1'b1;
      stall_m = '0;
      flush_m = '0;
      @(posedge clk);
      #1;
      step("first_run", 6'b0, O_RUN, 1'b0, 1'b0);

      // hazard masks a concurrent branch; the branch wins next cycle
      do_reset();
      step("hz_br", I_HZ | I_BR, O_HZ, 1'b0, 1'b0);
      step("br_after", I_BR, O_BR, 1'b0, 1'b0);
      chk("hzbr_stall", 32'(stall_cycles), 32'd1);
      chk("hzbr_flush", 32'(flush_count), 32'd1);

      // single-cycle RUN vectors
      do_reset();
      for (int i = 0; i < 10; i++)
         step($sformatf("tbl%0d", i), tbl[i].in, tbl[i].o, 1'b0, 1'b0);
      chk_cnt("tbl");

      // 5-cycle data access; halt/branch ignored while waiting
      do_reset();
      step("dw0", I_DS, O_FRZ, 1'b0, 1'b0);
      step("dw1", I_DS | I_BR | I_HL, O_FRZ, 1'b0, 1'b0);
      step("dw2", I_DS, O_FRZ, 1'b0, 1'b0);
      step("dw3", I_DS | I_HZ, O_FRZ, 1'b0, 1'b0);
      step("dw_done", I_DS | I_DD | I_HZ | I_BR, O_RUN, 1'b0, 1'b0);
      chk("dw_stall", 32'(stall_cycles), 32'd4);
      step("dw_back", I_HZ, O_HZ, 1'b0, 1'b0);
      chk_cnt("dw");

      // data memory timeout: ERR after 65 stalled cycles
      do_reset();
      for (int i = 0; i < 65; i++)
         step("to_wait", I_DS, O_FRZ, 1'b0, 1'b0);
      step("to_err", I_DS | I_DD, O_FRZ, 1'b0, 1'b1);
      step("to_err_hold", 6'b0, O_FRZ, 1'b0, 1'b1);
      chk("to_stall", 32'(stall_cycles), 32'd65);
      do_reset();
      step("to_cleared", 6'b0, O_RUN, 1'b0, 1'b0);

      // imem stall with and without a redirect
      do_reset();
      step("im_br", I_IM | I_BR, O_BRC, 1'b0, 1'b0);
      step("im_only", I_IM, O_IM, 1'b0, 1'b0);
      chk_cnt("im");

      // halt, then asynchronous reset mid-cycle
      do_reset();
      step("halt_req", I_HL, O_FRZ, 1'b0, 1'b0);
      step("halted1", I_BR, O_FRZ, 1'b1, 1'b0);
      step("halted2", I_DD, O_FRZ, 1'b1, 1'b0);
      chk_cnt("halt");
      drive(6'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_halted", 32'(halted), 32'd0);
      chk("arst_outs", 32'(outs()), 32'(O_FRZ));
      chk("arst_stall", 32'(stall_cycles), 32'd0);
      #1;
      rst_n = 1'b1;
      stall_m = '0;
      flush_m = '0;
      @(posedge clk);
      #1;
      step("after_arst", 6'b0, O_RUN, 1'b0, 1'b0);

      // flush counter saturation
      do_reset();
      for (int i = 0; i < 260; i++)
         step("sat", I_IM, O_IM, 1'b0, 1'b0);
      chk("sat_flush", 32'(flush_count), 32'd255);
      chk_cnt("sat");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
